matrix_result_streamer: RTL and testbench
=========================================

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the first byte of every frame.
REQ-002 The block SHALL have parameter MAX_DIM, default 5, the largest legal row/column count.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port calc_done, input, 1, the calculation-complete level from the calculation unit.
REQ-006 The block SHALL have port calc_error, input, 1, the calculation-error flag, sampled with calc_done.
REQ-007 The block SHALL have port result, input, 5x5 array of 8 bits, the result matrix indexed [row][col].
REQ-008 The block SHALL have port result_rows, input, 3, the result row count.
REQ-009 The block SHALL have port result_cols, input, 3, the result column count.
REQ-010 The block SHALL have port tx_data, output, 8, the stream byte.
REQ-011 The block SHALL have port tx_valid, output, 1, marking tx_data as valid.
REQ-012 The block SHALL have port tx_ready, input, 1, sink acceptance.
REQ-013 The block SHALL have port busy, output, 1, high from capture until the last byte is accepted.
REQ-014 The block SHALL have port frame_done, output, 1, a one-cycle pulse on acceptance of the checksum byte.
REQ-015 The block SHALL have port overrun, output, 1, a one-cycle pulse when a capture is dropped.

Function
REQ-016 The block SHALL register calc_done and trigger on its 0->1 edge only; a held-high level SHALL NOT retrigger.
REQ-017 On a trigger in IDLE, the block SHALL snapshot result, rows, cols and error into internal registers in the same edge; later input changes SHALL NOT affect the frame.
REQ-018 The FSM SHALL have states IDLE, SYNC, HDR, DATA and CSUM; IDLE->SYNC on trigger, SYNC->HDR, HDR->DATA (payload) or HDR->CSUM (no payload), DATA->CSUM after the last element, CSUM->IDLE.
REQ-019 Every state transition except IDLE->SYNC SHALL occur only on a handshake (tx_valid && tx_ready).
REQ-020 tx_valid SHALL rise in the cycle after the trigger edge and SHALL NOT depend combinationally on tx_ready.
REQ-021 While tx_valid=1 and tx_ready=0, tx_data SHALL stay stable and tx_valid SHALL stay high.
REQ-022 The SYNC byte SHALL be SYNC_BYTE.
REQ-023 The HDR byte SHALL be {err, rows[2:0], 1'b0, cols[2:0]}.
REQ-024 err SHALL be calc_error OR rows==0 OR cols==0 OR rows>MAX_DIM OR cols>MAX_DIM.
REQ-025 The payload SHALL be present only when err=0 and SHALL be rows*cols bytes in row-major order.
REQ-026 Row and column counters SHALL wrap the column to 0 and increment the row at col==cols-1; DATA SHALL end at row==rows-1 AND col==cols-1.
REQ-027 The CSUM byte SHALL be the 8-bit modulo-256 sum of the HDR byte and all payload bytes, excluding SYNC_BYTE.
REQ-028 A trigger edge while busy=1 SHALL be dropped, SHALL pulse overrun for one cycle, and SHALL leave the frame in progress unaltered.
REQ-029 On the CSUM handshake, the block SHALL pulse frame_done for one cycle, set busy=0 in the next cycle, and accept a new trigger edge in that cycle.

Reset
REQ-030 Asserting rst_n low SHALL immediately force tx_valid=0, busy=0, frame_done=0, overrun=0, tx_data=8'h00, state IDLE, all counters and checksum to 0, and the done-edge register to 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no further bytes.
REQ-032 If calc_done is high when reset releases, the block SHALL trigger once, on the first clock after release.

Structure
REQ-033 MAX_DIM, the 8-bit element typedef, the 5x5 matrix typedef and the FSM state enum SHALL be defined in the shared package matrix_pkg.
REQ-034 The block SHALL be implemented as a single module with no sub-modules.

Verification
REQ-035 With a 2x3 result [[1,2,3],[4,5,6]], error=0 and tx_ready=1, the stream SHALL be A5, 23, 01, 02, 03, 04, 05, 06, 38, followed by one frame_done pulse.
REQ-036 With 5x5 all 8'hFF, the stream SHALL be A5, 55, 25xFF, 3C.
REQ-037 With calc_error=1 and 3x3 dimensions, the stream SHALL be A5, B3, B3, with no payload; with rows=0, cols=2 and error=0, the stream SHALL be A5, 82, 82.
REQ-038 With tx_ready toggling pseudo-randomly during the 2x3 case, the bytes SHALL be identical to REQ-035, and tx_data SHALL never change while valid and not ready.
REQ-039 A second calc_done edge during DATA SHALL pulse overrun once and leave the stream bytes unchanged; calc_done held high for 20 cycles SHALL produce exactly one frame.
REQ-040 Asserting rst_n during DATA of the 5x5 case SHALL drop tx_valid asynchronously, and a following 2x3 trigger SHALL produce exactly the REQ-035 stream.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and constants for the matrix result streamer.
package matrix_pkg;
    localparam int MAX_DIM = 5;
    typedef logic [7:0] elem_t;
    typedef elem_t [MAX_DIM-1:0][MAX_DIM-1:0] matrix_t;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_HDR, ST_DATA, ST_CSUM} state_t;
    function automatic elem_t hdr_byte(logic err, logic [2:0] rows, logic [2:0] cols);
        return {err, rows, 1'b0, cols};
    endfunction
endpackage

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures a result matrix on the calc_done edge and
// streams it as SYNC, HDR, row-major payload and checksum over valid/ready.
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int MAX_DIM = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       calc_done,
    input  logic       calc_error,
    input  matrix_t    result,
    input  logic [2:0] result_rows,
    input  logic [2:0] result_cols,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);
    state_t state_q, state_d;
    matrix_t mat_q, mat_d;
    logic [2:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
    logic err_q, err_d, done_q, done_d;
    elem_t csum_q, csum_d, data_q, data_d;
    logic valid_q, valid_d, busy_q, busy_d, fd_q, fd_d, ov_q, ov_d;
    logic trig, hs, last_col, in_err;
    logic [2:0] nxt_row, nxt_col;

    always_comb begin
        trig = calc_done & ~done_q;
        hs = valid_q & tx_ready;
        last_col = col_q == cols_q - 3'd1;
        nxt_col = last_col ? 3'd0 : col_q + 3'd1;
        nxt_row = last_col ? row_q + 3'd1 : row_q;
        in_err = calc_error | (result_rows == 3'd0) | (result_cols == 3'd0) |
                 (int'(result_rows) > MAX_DIM) | (int'(result_cols) > MAX_DIM);
        done_d = calc_done;
        state_d = state_q;
        mat_d = mat_q;
        rows_d = rows_q;
        cols_d = cols_q;
        err_d = err_q;
        row_d = row_q;
        col_d = col_q;
        csum_d = csum_q;
        data_d = data_q;
        valid_d = valid_q;
        busy_d = busy_q;
        fd_d = 1'b0;
        ov_d = trig & (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (trig) begin
                state_d = ST_SYNC;
                mat_d = result;
                rows_d = result_rows;
                cols_d = result_cols;
                err_d = in_err;
                row_d = 3'd0;
                col_d = 3'd0;
                csum_d = 8'h00;
                data_d = SYNC_BYTE;
                valid_d = 1'b1;
                busy_d = 1'b1;
            end
            ST_SYNC: if (hs) begin
                state_d = ST_HDR;
                data_d = hdr_byte(err_q, rows_q, cols_q);
                csum_d = hdr_byte(err_q, rows_q, cols_q);
            end
            ST_HDR: if (hs) begin
                state_d = err_q ? ST_CSUM : ST_DATA;
                data_d = err_q ? csum_q : mat_q[0][0];
                csum_d = err_q ? csum_q : csum_q + mat_q[0][0];
            end
            ST_DATA: if (hs) begin
                // csum_q already includes the byte on the wire
                if (last_col && row_q == rows_q - 3'd1) begin
                    state_d = ST_CSUM;
                    data_d = csum_q;
                end else begin
                    row_d = nxt_row;
                    col_d = nxt_col;
                    data_d = mat_q[nxt_row][nxt_col];
                    csum_d = csum_q + mat_q[nxt_row][nxt_col];
                end
            end
            ST_CSUM: if (hs) begin
                state_d = ST_IDLE;
                data_d = 8'h00;
                valid_d = 1'b0;
                busy_d = 1'b0;
                fd_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mat_q <= '0;
            rows_q <= 3'd0;
            cols_q <= 3'd0;
            err_q <= 1'b0;
            row_q <= 3'd0;
            col_q <= 3'd0;
            csum_q <= 8'h00;
            data_q <= 8'h00;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            fd_q <= 1'b0;
            ov_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mat_q <= mat_d;
            rows_q <= rows_d;
            cols_q <= cols_d;
            err_q <= err_d;
            row_q <= row_d;
            col_q <= col_d;
            csum_q <= csum_d;
            data_q <= data_d;
            valid_q <= valid_d;
            busy_q <= busy_d;
            fd_q <= fd_d;
            ov_q <= ov_d;
            done_q <= done_d;
        end
    end

    assign tx_data = data_q;
    assign tx_valid = valid_q;
    assign busy = busy_q;
    assign frame_done = fd_q;
    assign overrun = ov_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: directed frames checked against a byte-queue model
// built from the framing rules, plus literal pins on the model itself.
module tb_matrix_result_streamer;
    import matrix_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, calc_done = 1'b0, calc_error = 1'b0, tx_ready;
    matrix_t result = '0;
    logic [2:0] result_rows = 3'd0, result_cols = 3'd0;
    logic [7:0] tx_data;
    logic tx_valid, busy, frame_done, overrun;
    int errors = 0, checks = 0, frames = 0, overruns = 0;
    elem_t exp_q[$];
    bit fd_exp = 0, prev_stall = 0, rnd_ready = 0;
    elem_t prev_data;

    matrix_result_streamer dut (
        .clk(clk), .rst_n(rst_n), .calc_done(calc_done), .calc_error(calc_error),
        .result(result), .result_rows(result_rows), .result_cols(result_cols),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(matrix_t m, int r, int c, bit e);
        bit err = e || r == 0 || c == 0 || r > 5 || c > 5;
        elem_t h = {err, r[2:0], 1'b0, c[2:0]};
        int sum = h;
        exp_q.push_back(8'hA5);
        exp_q.push_back(h);
        if (!err)
            for (int i = 0; i < r; i++)
                for (int j = 0; j < c; j++) begin
                    exp_q.push_back(m[i][j]);
                    sum += m[i][j];
                end
        exp_q.push_back(sum[7:0]);
    endfunction

    initial forever begin
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #2;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            fd_exp = 0;
        end else begin
            chk("frame_done", frame_done, fd_exp);
            fd_exp = 0;
            if (frame_done) frames++;
            if (overrun) overruns++;
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
            end
            if (tx_valid) chk("busy_with_valid", busy, 1);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected none", tx_data);
                end else begin
                    chk("byte", tx_data, exp_q.pop_front());
                    if (exp_q.size() == 0) fd_exp = 1;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic pulse();
        @(posedge clk);
        #2 calc_done = 1'b1;
        @(posedge clk);
        #2 calc_done = 1'b0;
    endtask

    task automatic apply(matrix_t m, int r, int c, bit e);
        result = m;
        result_rows = 3'(r);
        result_cols = 3'(c);
        calc_error = e;
    endtask

    task automatic scramble();
        result = ~result;
        result_rows = 3'($urandom_range(0, 7));
        result_cols = 3'($urandom_range(0, 7));
        calc_error = ~calc_error;
    endtask

    task automatic wait_frames(int target, string name);
        int n = 0;
        while (frames < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk({name, "_frames"}, frames, target);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic run(matrix_t m, int r, int c, bit e, string name);
        int f0 = frames;
        apply(m, r, c, e);
        pulse();
        scramble();
        wait_frames(f0 + 1, name);
    endtask

    initial begin
        matrix_t m;
        int f0, o0;
        #12;
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ov", overrun, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) m[i][j] = elem_t'(i * 3 + j + 1);
        push_frame(m, 2, 3, 0);
        chk("model_2x3_len", exp_q.size(), 9);
        chk("model_2x3_hdr", exp_q[1], 8'h23);
        chk("model_2x3_csum", exp_q[8], 8'h38);
        run(m, 2, 3, 0, "f2x3");

        m = '1;
        push_frame(m, 5, 5, 0);
        chk("model_5x5_len", exp_q.size(), 28);
        chk("model_5x5_hdr", exp_q[1], 8'h55);
        chk("model_5x5_csum", exp_q[27], 8'h3C);
        run(m, 5, 5, 0, "f5x5");

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) m[i][j] = elem_t'($urandom);
        push_frame(m, 3, 3, 1);
        chk("model_err_len", exp_q.size(), 3);
        chk("model_err_hdr", exp_q[1], 8'hB3);
        chk("model_err_csum", exp_q[2], 8'hB3);
        run(m, 3, 3, 1, "ferr");

        push_frame(m, 0, 2, 0);
        chk("model_r0_hdr", exp_q[1], 8'h82);
        chk("model_r0_csum", exp_q[2], 8'h82);
        run(m, 0, 2, 0, "frow0");

        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) m[i][j] = elem_t'(i * 3 + j + 1);
        rnd_ready = 1;
        push_frame(m, 2, 3, 0);
        run(m, 2, 3, 0, "frnd");
        rnd_ready = 0;

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) m[i][j] = elem_t'(i * 16 + j);
        push_frame(m, 5, 5, 0);
        f0 = frames;
        o0 = overruns;
        apply(m, 5, 5, 0);
        pulse();
        repeat (4) @(posedge clk);
        #2 apply(~m, 2, 2, 0);
        pulse();
        scramble();
        wait_frames(f0 + 1, "fovr");
        chk("overrun_once", overruns, o0 + 1);

        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) m[i][j] = elem_t'(8'h40 + i * 3 + j);
        push_frame(m, 2, 3, 0);
        f0 = frames;
        o0 = overruns;
        apply(m, 2, 3, 0);
        @(posedge clk);
        #2 calc_done = 1'b1;
        repeat (20) @(posedge clk);
        #2 calc_done = 1'b0;
        wait_frames(f0 + 1, "fheld");
        chk("held_no_overrun", overruns, o0);

        m = '1;
        push_frame(m, 5, 5, 0);
        apply(m, 5, 5, 0);
        pulse();
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_valid", tx_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_data", tx_data, 0);
        exp_q.delete();
        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) m[i][j] = elem_t'(i * 3 + j + 1);
        push_frame(m, 2, 3, 0);
        f0 = frames;
        o0 = overruns;
        apply(m, 2, 3, 0);
        calc_done = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2 calc_done = 1'b0;
        scramble();
        wait_frames(f0 + 1, "fpostrst");
        chk("postrst_no_overrun", overruns, o0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
